// File: rtl/mole_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mole_pkg
// Brief    : Shared types, constants and helpers for the mole game controller
// Revision : 1.0 - initial release
// ============================================================================
package mole_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GAP   = 3'd1,
        UP    = 3'd2,
        FLASH = 3'd3,
        OVER  = 3'd4
    } state_e;

    localparam int         NUM_OVALS = 5;
    localparam logic [2:0] NO_MOLE   = 3'd7;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // Fibonacci step: feedback from the tapped bits shifts in at bit 0
    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_TAPS)};
    endfunction

    function automatic logic [2:0] pick_idx(input logic [2:0] raw, input logic [2:0] prev);
        logic [2:0] idx;
        idx = (raw > 3'd4) ? raw - 3'd3 : raw;
        if (idx == prev) begin
            idx = (idx == 3'd4) ? 3'd0 : idx + 3'd1;
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mole_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : mole_controller_if
// Brief    : Player inputs and game-status outputs of the mole controller
// Revision : 1.0 - initial release
// ============================================================================
interface mole_controller_if;

    logic                           start;
    logic [mole_pkg::NUM_OVALS-1:0] btn;
    logic [2:0]                     oval_select;
    logic [7:0]                     score;
    logic [2:0]                     misses;
    logic                           hit_flash;
    logic                           miss_pulse;
    logic                           game_over;

    modport master (
        output start, btn,
        input  oval_select, score, misses, hit_flash, miss_pulse, game_over
    );

    modport slave (
        input  start, btn,
        output oval_select, score, misses, hit_flash, miss_pulse, game_over
    );

endinterface
`default_nettype wire

// File: rtl/btn_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : btn_sync_edge
// Brief    : Per-bit 2-FF synchronizer with registered rising-edge detect
// Revision : 1.0 - initial release
// ============================================================================
module btn_sync_edge #(
    parameter int W = 1
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic [W-1:0] i_raw,
    output logic      [W-1:0] o_edge
);

    logic [W-1:0] sync1_q, sync1_d;
    logic [W-1:0] sync2_q, sync2_d;
    logic [W-1:0] prev_q,  prev_d;

    always_comb begin
        sync1_d = i_raw;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign o_edge = sync2_q & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/mole_controller.sv
`default_nettype none
// ============================================================================
// Module   : mole_controller
// Brief    : Whack-a-mole game FSM: random hole choice, up-window timing,
//            hit/miss detection, score and game-over tracking
// Revision : 1.0 - initial release
// ============================================================================
module mole_controller
    import mole_pkg::*;
#(
    parameter int unsigned UP_TICKS    = 100_000_000,
    parameter int unsigned GAP_TICKS   = 50_000_000,
    parameter int unsigned FLASH_TICKS = 10_000_000,
    parameter int unsigned MAX_MISSES  = 3,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input wire logic          clk,
    input wire logic          rst,
    mole_controller_if.slave  bus
);

    localparam logic [31:0] c_up_last    = 32'(UP_TICKS - 1);
    localparam logic [31:0] c_gap_last   = 32'(GAP_TICKS - 1);
    localparam logic [31:0] c_flash_last = 32'(FLASH_TICKS - 1);
    localparam logic [2:0]  c_max_miss   = 3'(MAX_MISSES);

    logic [NUM_OVALS-1:0] w_btn_edge;
    logic [0:0]           w_start_edge;
    logic [NUM_OVALS-1:0] w_target;
    logic [2:0]           w_idx;

    state_e      state_q, state_d;
    logic [31:0] timer_q, timer_d;
    logic [7:0]  lfsr_q, lfsr_d;
    logic [2:0]  prev_idx_q, prev_idx_d;
    logic [2:0]  oval_select_q, oval_select_d;
    logic [7:0]  score_q, score_d;
    logic [2:0]  misses_q, misses_d;
    logic        hit_flash_q, hit_flash_d;
    logic        miss_pulse_q, miss_pulse_d;
    logic        game_over_q, game_over_d;

    btn_sync_edge #(.W(NUM_OVALS)) u_btn_sync (
        .clk    (clk),
        .rst    (rst),
        .i_raw  (bus.btn),
        .o_edge (w_btn_edge)
    );

    btn_sync_edge #(.W(1)) u_start_sync (
        .clk    (clk),
        .rst    (rst),
        .i_raw  (bus.start),
        .o_edge (w_start_edge)
    );

    assign w_target = {{(NUM_OVALS-1){1'b0}}, 1'b1} << oval_select_q;
    assign w_idx    = pick_idx(lfsr_q[2:0], prev_idx_q);

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q + 32'd1;
        lfsr_d        = lfsr_next(lfsr_q);
        prev_idx_d    = prev_idx_q;
        oval_select_d = oval_select_q;
        score_d       = score_q;
        misses_d      = misses_q;
        miss_pulse_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (w_start_edge[0]) begin
                    state_d  = GAP;
                    score_d  = '0;
                    misses_d = '0;
                end
            end
            GAP: begin
                if (timer_q == c_gap_last) begin
                    state_d       = UP;
                    oval_select_d = w_idx;
                    prev_idx_d    = w_idx;
                end
            end
            UP: begin
                // Exact one-hot match wins even in the expiry cycle
                if (w_btn_edge == w_target) begin
                    state_d = FLASH;
                    score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                end else if ((w_btn_edge != '0) || (timer_q == c_up_last)) begin
                    misses_d      = misses_q + 3'd1;
                    miss_pulse_d  = 1'b1;
                    oval_select_d = NO_MOLE;
                    state_d       = (misses_d == c_max_miss) ? OVER : GAP;
                end
            end
            FLASH: begin
                if (timer_q == c_flash_last) begin
                    state_d       = GAP;
                    oval_select_d = NO_MOLE;
                end
            end
            OVER: begin
                if (w_start_edge[0]) begin
                    state_d  = GAP;
                    score_d  = '0;
                    misses_d = '0;
                end
            end
            default: begin
                state_d       = IDLE;
                oval_select_d = NO_MOLE;
            end
        endcase

        if (state_d != state_q) begin
            timer_d = '0;
        end
        hit_flash_d = (state_d == FLASH);
        game_over_d = (state_d == OVER);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            lfsr_q        <= LFSR_SEED;
            prev_idx_q    <= '0;
            oval_select_q <= NO_MOLE;
            score_q       <= '0;
            misses_q      <= '0;
            hit_flash_q   <= 1'b0;
            miss_pulse_q  <= 1'b0;
            game_over_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            lfsr_q        <= lfsr_d;
            prev_idx_q    <= prev_idx_d;
            oval_select_q <= oval_select_d;
            score_q       <= score_d;
            misses_q      <= misses_d;
            hit_flash_q   <= hit_flash_d;
            miss_pulse_q  <= miss_pulse_d;
            game_over_q   <= game_over_d;
        end
    end

    assign bus.oval_select = oval_select_q;
    assign bus.score       = score_q;
    assign bus.misses      = misses_q;
    assign bus.hit_flash   = hit_flash_q;
    assign bus.miss_pulse  = miss_pulse_q;
    assign bus.game_over   = game_over_q;

endmodule
`default_nettype wire

// File: doc/mole_controller.md
Name: mole_controller

Overview:
Game-control stage directly upstream of the oval renderer. It produces the oval_select index that decides which of the 5 holes shows the mole, using a pseudo-random LFSR. It times each mole's up-window, detects player hits from 5 raw push-buttons, and keeps score, miss count and game-over state.

Parameters:
UP_TICKS, 100_000_000, clk cycles a mole stays up (1 s at 100 MHz)
GAP_TICKS, 50_000_000, clk cycles with no mole between rounds
FLASH_TICKS, 10_000_000, clk cycles hit_flash stays asserted after a hit
MAX_MISSES, 3, misses that end the game (1..7)
LFSR_SEED, 8'hA5, LFSR reset value (must be non-zero)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
start  in  1  raw start button, asynchronous to clk
btn  in  5  raw hole buttons, bit i = oval i, asynchronous
oval_select  out  3  0..4 = mole in that oval; 3'd7 = no mole
score  out  8  hits this game, saturates at 255
misses  out  3  misses this game
hit_flash  out  1  high during the FLASH state
miss_pulse  out  1  one-cycle pulse on each miss
game_over  out  1  high in the OVER state

Behaviour:
- Reset (rst low, asynchronous): state IDLE, oval_select 7, score 0, misses 0, hit_flash 0, miss_pulse 0, game_over 0, LFSR = LFSR_SEED, prev_idx 0, timer 0, synchronizers 0.
- Inputs: every start/btn bit passes through a 2-FF synchronizer plus a registered previous value. Edge = sync2 & ~prev.
- Edge latency: the FSM acts on the 3rd rising clk edge at which the raw input is high. A held button produces exactly one edge.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. Advances every cycle in every state.
- Index selection:
  - raw = lfsr[2:0].
  - If raw > 4, idx = raw - 3.
  - If idx == prev_idx, idx = (idx == 4) ? 0 : idx + 1.
  - prev_idx is updated when the mole is raised.
- Timer: 32-bit. Cleared on every state entry. Expiry when timer == N-1.
- FSM transitions:
  - IDLE: oval_select 7. start edge -> GAP; score and misses cleared.
  - GAP: oval_select 7. Expiry -> UP; idx latched to oval_select.
  - UP, single btn edge on bit oval_select (one-hot match) -> FLASH; score += 1, saturating.
  - UP, any other non-zero btn edge vector, including multi-bit vectors that contain the correct bit -> miss.
  - UP, expiry with no btn edge -> miss.
  - A correct hit in the expiry cycle counts as a hit, not a miss.
- Miss handling:
  - misses += 1 and miss_pulse = 1 for that cycle.
  - If the new misses == MAX_MISSES -> OVER, else -> GAP.
  - oval_select goes to 7 on the same edge.
- FLASH: oval_select holds the hit index, hit_flash 1, btn edges ignored. Expiry -> GAP, hit_flash 0.
- OVER: oval_select 7, game_over 1, score and misses frozen. start edge -> GAP; score and misses cleared, game_over 0.
- Other edge rules:
  - start edges outside IDLE/OVER are ignored.
  - btn edges outside UP are ignored.
- All outputs are registered. No combinational path from any input to any output.
- Reset mid-round returns to IDLE immediately. No partial score is retained.

Decomposition:
- Package mole_pkg:
  - state enum {IDLE, GAP, UP, FLASH, OVER}
  - NUM_OVALS = 5
  - NO_MOLE = 3'd7
  - LFSR tap mask 8'hB8
- Sub-module btn_sync_edge, parameter W:
  - 2-FF synchronizer plus rising-edge detect per bit, same clk/rst.
  - Instantiated once for btn (W=5) and once for start (W=1).

Test Plan:
1. Reset release, no inputs, 1000 cycles -> state IDLE, oval_select 7, score 0, misses 0, game_over 0 throughout.
2. UP_TICKS=20, GAP_TICKS=10, FLASH_TICKS=5; pulse start -> GAP entered on the 3rd edge. After 10 cycles oval_select = idx derived from the LFSR (seed A5); the bench model matches each round and never repeats the previous index.
3. In UP, press btn[oval_select] for 4 cycles -> score 1, hit_flash high for 5 cycles with oval_select held, then oval_select 7 for 10 cycles. Holding the button gives no second hit.
4. In UP, press a wrong button, or btn 5'b11111 -> misses +1, one-cycle miss_pulse, oval_select 7 next cycle. No input for 20 cycles in UP -> miss at timer == 19.
5. Correct btn edge arriving exactly in the expiry cycle -> counted as a hit (score +1, misses unchanged).
6. Three misses -> OVER, game_over 1, score frozen. start edge -> score 0, misses 0, GAP. Mid-UP rst low -> all outputs reach reset values asynchronously, before the next clk edge.
